// File: rtl/baud_uart_tx_pkg.sv
// Shared types and constants for the baud-clocked UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, idle line level.
package baud_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/baud_uart_tx_if.sv
// Parallel word handshake into the UART transmitter.
// Latency: n/a (wires only).
// Backpressure: word transfers on a cycle where valid and ready are both high.
// Signals: data (word), valid (producer has a word), ready (consumer accepts).
interface baud_uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/baud_uart_tx_rise_detect.sv
// Rising-edge detector for a same-domain square wave (bit timing strobe).
// Latency: tick_o is combinational, high for the one cycle after sig_i rises.
// Backpressure: none.
// Ports: clk, resetn, sig_i (square wave), tick_o (one-cycle rise strobe).
module baud_uart_tx_rise_detect (
  input  logic clk,
  input  logic resetn,
  input  logic sig_i,
  output logic tick_o
);

  logic prev_q;

  // Reset to 1 so a wave that is already high at release is not seen as a rise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign tick_o = sig_i & ~prev_q;

endmodule

// File: rtl/baud_uart_tx.sv
// UART transmitter: start + DATA_BITS (LSB first) + STOP_BITS, one bit per baud_clk rise.
// Latency: tx falls on the first tick after accept (0..1 baud period); frame is 1+DATA_BITS+STOP_BITS ticks.
// Backpressure: ready is high only while idle; a valid without ready is held by the producer.
// Ports: clk, resetn (async low), baud_clk, in_if (data/valid/ready), tx (idle high), busy.
module baud_uart_tx
  import baud_uart_tx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            baud_clk,
  baud_uart_tx_if.slave   in_if,
  output logic            tx,
  output logic            busy
);

  localparam int BCW = $clog2(DATA_BITS + 1);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]       bitcnt_q, bitcnt_d;
  logic [1:0]           stopcnt_q, stopcnt_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 tick;
  logic                 accept;

  baud_uart_tx_rise_detect u_rise (
    .clk    (clk),
    .resetn (resetn),
    .sig_i  (baud_clk),
    .tick_o (tick)
  );

  // ready is only ever high in IDLE, so accept implies IDLE.
  assign accept = in_if.valid & ready_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    stopcnt_d = stopcnt_q;
    tx_d      = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = TX_IDLE_LEVEL;
        // A tick coinciding with accept is deliberately ignored; SYNC waits
        // for the next one so the start bit lasts a full baud period.
        if (accept) begin
          shreg_d = in_if.data;
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (tick) begin
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d  = DATA;
          tx_d     = shreg_q[0];
          shreg_d  = shreg_q >> 1;
          bitcnt_d = BCW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          if (bitcnt_q == BCW'(DATA_BITS)) begin
            state_d   = STOP;
            tx_d      = TX_IDLE_LEVEL;
            stopcnt_d = 2'd1;
          end else begin
            tx_d     = shreg_q[0];
            shreg_d  = shreg_q >> 1;
            bitcnt_d = bitcnt_q + BCW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (stopcnt_q == 2'(STOP_BITS)) begin
            state_d = IDLE;
          end else begin
            stopcnt_d = stopcnt_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = TX_IDLE_LEVEL;
      end
    endcase
    // Registered from next state: ready rises on the first edge after reset
    // release and on the final stop tick, and drops on the accept edge.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      stopcnt_q <= '0;
      tx_q      <= TX_IDLE_LEVEL;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      stopcnt_q <= stopcnt_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
    end
  end

  assign tx          = tx_q;
  assign busy        = (state_q != IDLE);
  assign in_if.ready = ready_q;

endmodule

// File: tb/tb_baud_uart_tx.sv
// Directed bench for baud_uart_tx: 8N1 instance and 7N2 instance sharing clock, reset and baud wave.
// Baud wave is 10 clk per bit, generated from clk and freezable at its current level.
// Frames are checked sample-by-sample on every falling clk edge.
module tb_baud_uart_tx;

  logic clk = 1'b0;
  logic resetn;
  logic baud_clk = 1'b0;
  logic baud_freeze = 1'b0;
  int   bcnt = 0;
  logic tx1, busy1, tx2, busy2;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;

  baud_uart_tx_if #(.DATA_BITS(8)) if1 ();
  baud_uart_tx_if #(.DATA_BITS(7)) if2 ();

  baud_uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) dut1 (
    .clk      (clk),
    .resetn   (resetn),
    .baud_clk (baud_clk),
    .in_if    (if1),
    .tx       (tx1),
    .busy     (busy1)
  );

  baud_uart_tx #(.DATA_BITS(7), .STOP_BITS(2)) dut2 (
    .clk      (clk),
    .resetn   (resetn),
    .baud_clk (baud_clk),
    .in_if    (if2),
    .tx       (tx2),
    .busy     (busy2)
  );

  always #5 clk = ~clk;

  // Clock stage model: 12 MHz / 10, square wave toggling every 5 clk.
  always @(posedge clk) begin
    if (!baud_freeze) begin
      if (bcnt == 4) begin
        bcnt     <= 0;
        baud_clk <= ~baud_clk;
      end else begin
        bcnt <= bcnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (busy1 === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_tx(input int sel);
    return (sel == 2) ? tx2 : tx1;
  endfunction

  // Waits for tx to fall; on return the current falling clk edge is the first
  // sample of the start bit. waited counts the falling edges consumed.
  task automatic wait_start(input int sel, input string tag, output int waited, output logic ok);
    logic t;
    waited = 0;
    t = 1'b1;
    while (waited < 40 && t !== 1'b0) begin
      @(negedge clk);
      waited++;
      t = cur_tx(sel);
    end
    chk({tag, " start seen"}, t, 1'b0);
    ok = (t === 1'b0);
  endtask

  // bits[i] is frame bit i (start first); each must last exactly 10 clk.
  // frz >= 0 freezes the baud wave for 200 clk from that sample on.
  task automatic frame_check(input int sel, input logic [9:0] bits, input int frz,
                             input string tag, output int waited);
    logic ok;
    int   n, e;
    wait_start(sel, tag, waited, ok);
    if (ok) begin
      n = (frz >= 0) ? 300 : 100;
      for (int k = 0; k < n; k++) begin
        if (k > 0) @(negedge clk);
        if (frz < 0 || k < frz) e = k;
        else if (k < frz + 200) e = frz;
        else e = k - 200;
        if (frz >= 0 && k == frz) baud_freeze = 1'b1;
        if (frz >= 0 && k == frz + 200) baud_freeze = 1'b0;
        if (frz >= 0 && k == frz + 100)
          chk({tag, " busy frozen"}, (sel == 2) ? busy2 : busy1, 1'b1);
        chk($sformatf("%s bit%0d", tag, e / 10), cur_tx(sel), bits[e / 10]);
      end
    end
  endtask

  task automatic send(input int sel, input logic [7:0] d);
    logic r;
    int   g;
    g = 0;
    @(negedge clk);
    r = (sel == 2) ? if2.ready : if1.ready;
    while (r !== 1'b1 && g < 300) begin
      @(negedge clk);
      g++;
      r = (sel == 2) ? if2.ready : if1.ready;
    end
    chk($sformatf("ready before send %0d", sel), r, 1'b1);
    if (sel == 2) begin
      if2.data  = d[6:0];
      if2.valid = 1'b1;
    end else begin
      if1.data  = d;
      if1.valid = 1'b1;
    end
    @(negedge clk);
    if1.valid = 1'b0;
    if2.valid = 1'b0;
  endtask

  task automatic idle_check(input int sel, input string tag);
    @(negedge clk);
    chk({tag, " busy after"}, (sel == 2) ? busy2 : busy1, 1'b0);
    chk({tag, " ready after"}, (sel == 2) ? if2.ready : if1.ready, 1'b1);
    chk({tag, " tx after"}, cur_tx(sel), 1'b1);
  endtask

  initial begin
    int   w, w2, bc0, lows, g, n;
    logic ok, r;

    resetn    = 1'b0;
    if1.valid = 1'b0;
    if1.data  = '0;
    if2.valid = 1'b0;
    if2.data  = '0;

    // 1. Reset with the baud wave running.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst tx", tx1, 1'b1);
      chk("rst ready", if1.ready, 1'b0);
      chk("rst busy", busy1, 1'b0);
    end
    resetn = 1'b1;
    chk("ready before first edge", if1.ready, 1'b0);
    @(negedge clk);
    chk("ready first edge", if1.ready, 1'b1);
    chk("ready2 first edge", if2.ready, 1'b1);
    chk("tx idle", tx1, 1'b1);

    // 2. 0xA5, 8N1 -> 0,1,0,1,0,0,1,0,1,1.
    bc0 = busy_cnt;
    send(1, 8'hA5);
    chk("A5 ready drop", if1.ready, 1'b0);
    chk("A5 busy", busy1, 1'b1);
    frame_check(1, 10'h34A, -1, "A5", w);
    idle_check(1, "A5");
    chk("A5 busy length", ((busy_cnt - bc0) >= 101 && (busy_cnt - bc0) <= 110), 1'b1);

    // 3. valid held through 0x00 then 0xFF.
    fork
      begin
        if1.data  = 8'h00;
        if1.valid = 1'b1;
        n = 0;
        g = 0;
        while (n < 2 && g < 400) begin
          r = if1.ready;
          @(negedge clk);
          g++;
          if (r === 1'b1) begin
            n++;
            if (n == 1) if1.data = 8'hFF;
            else if1.valid = 1'b0;
          end
        end
        if1.valid = 1'b0;
        chk("held valid accepts", n, 2);
      end
      begin
        frame_check(1, 10'h200, -1, "x00", w);
        frame_check(1, 10'h3FE, -1, "xFF", w2);
        chk("b2b gap clk", w2 - 1, 10);
      end
    join
    idle_check(1, "xFF");

    // 4. 7N2 instance, 0x41 -> 0,1,0,0,0,0,0,1,1,1; stop phase 20 clk.
    send(2, 8'h41);
    frame_check(2, 10'h382, -1, "x41", w);
    idle_check(2, "x41");

    // 5. Reset in the middle of data bit 3 of 0x00.
    send(1, 8'h00);
    wait_start(1, "rstmid", w, ok);
    repeat (45) @(negedge clk);
    chk("rstmid bit3 low", tx1, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("rstmid tx async", tx1, 1'b1);
    chk("rstmid busy", busy1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx1 !== 1'b1) lows++;
    end
    chk("rstmid no resume", lows, 0);
    send(1, 8'h55);
    frame_check(1, 10'h2AA, -1, "x55", w);
    idle_check(1, "x55");

    // 6. Baud wave frozen high for 200 clk during data bit 2 of 0xA5.
    send(1, 8'hA5);
    frame_check(1, 10'h34A, 32, "frz", w);
    idle_check(1, "frz");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
